// File: rtl/vertex_fetch.sv
// ---------------------------------------------------------------------------
// vertex_fetch
//
// Purpose:
//   Fetches a batch of 3-component vertices (x, y, z as IEEE-754 singles)
//   from a fixed-latency word memory. Each vertex is presented as a
//   homogeneous 4-vector (w = 1.0) to a downstream matrix transform. Only
//   one vertex is outstanding at a time. The next vertex is fetched only
//   after the transform reports that it has consumed the current one.
//
// Parameters:
//   ADDR_WIDTH    vertex memory word address width
//   READ_LATENCY  cycles from rd_en_out to data_in valid (1..4)
//
// Ports:
//   clk_in         system clock, all logic on posedge
//   rst_in         asynchronous active-high reset
//   start_in       begin a batch (sampled in IDLE only)
//   base_addr_in   word address of vertex 0, x component
//   num_verts_in   number of vertices in the batch
//   addr_out       memory read address (holds when not reading)
//   rd_en_out      memory read strobe, one word per cycle
//   data_in        memory read data, READ_LATENCY cycles after rd_en_out
//   vec_out        {w, z, y, x} vertex for the transform ([0] = x)
//   vec_valid_out  one-cycle pulse, vec_out valid
//   xform_done_in  transform has consumed the current vertex
//   vert_idx_out   index of the vertex currently held in vec_out
//   busy_out       high whenever a batch is in progress
//   done_out       one-cycle pulse at batch completion
// ---------------------------------------------------------------------------
module vertex_fetch #(
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [15:0]           num_verts_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  rd_en_out,
  input  logic [31:0]           data_in,
  output logic [3:0][31:0]      vec_out,
  output logic                  vec_valid_out,
  input  logic                  xform_done_in,
  output logic [15:0]           vert_idx_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    SEND,
    WAIT_XFORM
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             num_verts_q, num_verts_d;
  logic [15:0]             vert_idx_q, vert_idx_d;
  logic [1:0]              issue_cnt_q, issue_cnt_d;
  logic [1:0]              cap_cnt_q, cap_cnt_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [3:0][31:0]        vec_q, vec_d;
  logic                    done_q, done_d;

  logic issuing;
  logic word_arrives;
  logic last_word;
  logic last_vertex;

  assign issuing      = (state_q == ISSUE);
  // The oldest stage of the valid pipe marks the cycle data_in carries a
  // word we asked for. Data is tracked by this pipe rather than by the FSM
  // so a latency change never requires retiming the state machine.
  assign word_arrives = vld_q[READ_LATENCY-1];
  assign last_word    = word_arrives && (cap_cnt_q == 2'd2);
  assign last_vertex  = (vert_idx_q == (num_verts_q - 16'd1));

  // Next-state and datapath logic. Every _d defaults to its _q so that
  // registers hold unless a branch below says otherwise.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    num_verts_d = num_verts_q;
    vert_idx_d  = vert_idx_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    vec_d       = vec_q;
    done_d      = 1'b0;

    // Read-valid shift register: a strobe enters at stage 0 and emerges
    // READ_LATENCY cycles later alongside its data.
    vld_d    = '0;
    vld_d[0] = issuing;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    // Returned words fill x, y, z in order; the counter wraps after z so
    // the next vertex starts again at x.
    if (word_arrives) begin
      vec_d[cap_cnt_q] = data_in;
      cap_cnt_d        = (cap_cnt_q == 2'd2) ? 2'd0 : cap_cnt_q + 2'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          if (num_verts_in != 16'd0) begin
            num_verts_d = num_verts_in;
            vert_idx_d  = 16'd0;
            addr_d      = base_addr_in;
            issue_cnt_d = 2'd0;
            cap_cnt_d   = 2'd0;
            state_d     = ISSUE;
          end else begin
            // Empty batch: nothing to read, report completion at once.
            done_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        // Three back-to-back reads. The address stops on z so it holds
        // the last address read while the FSM waits.
        if (issue_cnt_q == 2'd2) begin
          issue_cnt_d = 2'd0;
          state_d     = WAIT_DATA;
        end else begin
          issue_cnt_d = issue_cnt_q + 2'd1;
          addr_d      = addr_q + ADDR_WIDTH'(1);
        end
      end

      WAIT_DATA: begin
        if (last_word) begin
          vec_d[3] = FLOAT_ONE;
          state_d  = SEND;
        end
      end

      SEND: begin
        state_d = WAIT_XFORM;
      end

      WAIT_XFORM: begin
        if (xform_done_in) begin
          if (last_vertex) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            // Vertices are packed back to back, so the next x sits one
            // word past the previous z (wrapping at the top of memory).
            vert_idx_d = vert_idx_q + 16'd1;
            addr_d     = addr_q + ADDR_WIDTH'(1);
            state_d    = ISSUE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset also flushes the read-valid pipe,
  // so words from an aborted batch that return later are never captured.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      num_verts_q <= '0;
      vert_idx_q  <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      vld_q       <= '0;
      vec_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      num_verts_q <= num_verts_d;
      vert_idx_q  <= vert_idx_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      vld_q       <= vld_d;
      vec_q       <= vec_d;
      done_q      <= done_d;
    end
  end

  assign addr_out      = addr_q;
  assign rd_en_out     = issuing;
  assign vec_out       = vec_q;
  assign vec_valid_out = (state_q == SEND);
  assign vert_idx_out  = vert_idx_q;
  assign busy_out      = (state_q != IDLE);
  assign done_out      = done_q;

endmodule

// File: tb/tb_vertex_fetch.sv
// ---------------------------------------------------------------------------
// tb_vertex_fetch
//
// Builds a cycle-indexed timeline of every batch (reads, presentation,
// transform handshake, completion) from plain arithmetic on the batch
// parameters, then drives the DUT from that timeline and compares all
// outputs every cycle. A fixed-latency memory model answers the reads.
// ---------------------------------------------------------------------------
module tb_vertex_fetch;

  localparam int AW   = 16;
  localparam int LAT  = 2;
  localparam int MAXC = 4096;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            start_in;
  logic [AW-1:0]   base_addr_in;
  logic [15:0]     num_verts_in;
  logic [AW-1:0]   addr_out;
  logic            rd_en_out;
  logic [31:0]     data_in;
  logic [3:0][31:0] vec_out;
  logic            vec_valid_out;
  logic            xform_done_in;
  logic [15:0]     vert_idx_out;
  logic            busy_out;
  logic            done_out;

  vertex_fetch #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .base_addr_in  (base_addr_in),
    .num_verts_in  (num_verts_in),
    .addr_out      (addr_out),
    .rd_en_out     (rd_en_out),
    .data_in       (data_in),
    .vec_out       (vec_out),
    .vec_valid_out (vec_valid_out),
    .xform_done_in (xform_done_in),
    .vert_idx_out  (vert_idx_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  always #5 clk_in = ~clk_in;

  // Per-cycle stimulus plan
  bit          drv_rst   [MAXC];
  bit          drv_start [MAXC];
  bit          drv_xdone [MAXC];
  logic [15:0] drv_base  [MAXC];
  logic [15:0] drv_num   [MAXC];

  // Per-cycle expectations
  bit           exp_rd   [MAXC];
  bit           exp_vv   [MAXC];
  bit           exp_busy [MAXC];
  bit           exp_done [MAXC];
  bit           exp_hold [MAXC];
  bit           exp_rst  [MAXC];
  logic [15:0]  exp_ra   [MAXC];
  logic [15:0]  exp_addr [MAXC];
  logic [15:0]  exp_idx  [MAXC];
  logic [127:0] exp_vec  [MAXC];

  // Hand-computed literal pins: kind 0 = read address, 1 = presented
  // vector, 2 = done pulse, 3 = vertex index
  int           lit_cyc  [$];
  int           lit_kind [$];
  logic [127:0] lit_val  [$];

  int  n_pass  = 0;
  int  n_total = 0;
  int  cur_k   = 0;
  bit  running = 1'b0;

  // Memory contents: three known floats at 0x10..0x12, a fixed address
  // hash elsewhere.
  function automatic logic [31:0] memword(input logic [15:0] a);
    case (a)
      16'h0010: return 32'h3F80_0000;
      16'h0011: return 32'h4000_0000;
      16'h0012: return 32'h4040_0000;
      default:  return {~a, a} ^ 32'hC0DE_F00D;
    endcase
  endfunction

  // Fixed-latency memory. It is not reset: words for reads issued before
  // a reset still come back afterwards, and the DUT must ignore them.
  bit          mv [LAT];
  logic [15:0] ma [LAT];
  logic [31:0] garbage = 32'h0;

  always @(posedge clk_in) begin
    for (int i = LAT - 1; i > 0; i--) begin
      mv[i] <= mv[i-1];
      ma[i] <= ma[i-1];
    end
    mv[0]   <= rd_en_out;
    ma[0]   <= addr_out;
    garbage <= $urandom;
  end

  always @* data_in = mv[LAT-1] ? memword(ma[LAT-1]) : garbage;

  task automatic chk(input string name, input int k,
                     input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, k, act, exp);
  endtask

  // Plans one batch starting (start_in high) in cycle t0. Vertex i issues
  // in S..S+2, is presented at V = S+3+LAT, and is acknowledged at
  // U = V+1+delay; the next vertex issues at U+1 and completion is
  // signalled one cycle after the final acknowledge. abort_v >= 0 resets
  // the DUT in the first waiting cycle of that vertex.
  task automatic plan_batch(input int t0, input logic [15:0] base, input int n,
                            input int d0, input int d1, input int d2, input int d3,
                            input int abort_v, input bit spur, output int t_end);
    int dl[4];
    int s, v, u, stop;
    logic [15:0] a;
    logic [127:0] vec;
    dl = '{d0, d1, d2, d3};
    drv_start[t0] = 1'b1;
    drv_base[t0]  = base;
    drv_num[t0]   = 16'(n);
    if (n == 0) begin
      exp_done[t0+1] = 1'b1;
      t_end = t0 + 1;
      return;
    end
    s = t0 + 1;
    stop = MAXC;
    for (int i = 0; i < n; i++) begin
      if (i == abort_v) stop = s + 3;
      vec = {32'h3F80_0000, 96'h0};
      for (int c = 0; c < 3; c++) begin
        a = base + 16'(3 * i + c);
        vec[32*c +: 32] = memword(a);
        if (s + c < stop) begin
          exp_rd[s+c] = 1'b1;
          exp_ra[s+c] = a;
        end
      end
      v = s + 3 + LAT;
      u = v + 1 + dl[i];
      for (int k = s; k <= u; k++) begin
        if (k < stop) begin
          exp_busy[k] = 1'b1;
          if (spur && $urandom_range(0, 5) == 0) drv_start[k] = 1'b1;
          if (spur && k <= v && $urandom_range(0, 3) == 0) drv_xdone[k] = 1'b1;
          if (k >= v) begin
            exp_hold[k] = 1'b1;
            exp_vec[k]  = vec;
            exp_idx[k]  = 16'(i);
          end
        end
      end
      if (v < stop) exp_vv[v] = 1'b1;
      if (i == abort_v) begin
        drv_rst[stop] = 1'b1;
        exp_rst[stop] = 1'b1;
        t_end = stop + 1;
        return;
      end
      drv_xdone[u] = 1'b1;
      s = u + 1;
    end
    exp_done[s] = 1'b1;
    t_end = s;
  endtask

  task automatic add_lit(input int k, input int kind, input logic [127:0] val);
    lit_cyc.push_back(k);
    lit_kind.push_back(kind);
    lit_val.push_back(val);
  endtask

  // Idle gap between batches; stray acknowledges are sprinkled in.
  task automatic gap(inout int t, input int len);
    for (int k = t; k < t + len; k++) drv_xdone[k] = ($urandom_range(0, 1) == 1);
    t = t + len;
  endtask

  task automatic apply_stimulus(input int k);
    rst_in        = drv_rst[k];
    start_in      = drv_start[k];
    base_addr_in  = drv_base[k];
    num_verts_in  = drv_num[k];
    xform_done_in = drv_xdone[k];
  endtask

  task automatic check_output(input int k);
    chk("rd_en",    k, 160'(rd_en_out),     160'(exp_rd[k]));
    chk("addr",     k, 160'(addr_out),      160'(exp_addr[k]));
    chk("vec_valid",k, 160'(vec_valid_out), 160'(exp_vv[k]));
    chk("busy",     k, 160'(busy_out),      160'(exp_busy[k]));
    chk("done",     k, 160'(done_out),      160'(exp_done[k]));
    if (exp_hold[k]) begin
      chk("vec",      k, 160'(vec_out),      160'(exp_vec[k]));
      chk("vert_idx", k, 160'(vert_idx_out), 160'(exp_idx[k]));
    end
    if (exp_rst[k]) begin
      chk("rst_vec", k, 160'(vec_out),      160'(0));
      chk("rst_idx", k, 160'(vert_idx_out), 160'(0));
    end
    for (int j = 0; j < lit_cyc.size(); j++) begin
      if (lit_cyc[j] == k) begin
        case (lit_kind[j])
          0: chk("lit_addr", k, 160'({rd_en_out, addr_out}), 160'({1'b1, lit_val[j][15:0]}));
          1: chk("lit_vec",  k, 160'({vec_valid_out, vec_out}), {31'h0, 1'b1, lit_val[j]});
          2: chk("lit_done", k, 160'(done_out), 160'(1));
          default: chk("lit_idx", k, 160'(vert_idx_out), 160'(lit_val[j][15:0]));
        endcase
      end
    end
  endtask

  always @(negedge clk_in) if (running) check_output(cur_k);

  initial begin
    int t, te, endc, n;
    logic [15:0] cur;
    rst_in = 1'b1; start_in = 1'b0; base_addr_in = '0;
    num_verts_in = '0; xform_done_in = 1'b0;

    for (int k = 0; k < MAXC; k++) begin
      drv_base[k] = 16'($urandom);
      drv_num[k]  = 16'($urandom_range(0, 6));
      exp_vec[k]  = '0;
      exp_ra[k]   = '0;
      exp_idx[k]  = '0;
    end
    for (int k = 0; k < 3; k++) begin
      drv_rst[k] = 1'b1;
      exp_rst[k] = 1'b1;
    end

    // Single vertex with known floats, acknowledged 5 cycles after SEND
    t = 5;
    plan_batch(t, 16'h0010, 1, 4, 0, 0, 0, -1, 1'b0, te);
    add_lit(t+1, 0, 128'h10); add_lit(t+2, 0, 128'h11); add_lit(t+3, 0, 128'h12);
    add_lit(t+6, 1, {32'h3F80_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000});
    add_lit(t+12, 2, '0);
    t = te; gap(t, 3);

    // Batch of three, acknowledge delays 1, 7, 0, with stray pulses
    plan_batch(t, 16'h0200, 3, 1, 7, 0, 0, -1, 1'b1, te);
    add_lit(t+1, 0, 128'h200); add_lit(t+23, 0, 128'h206); add_lit(t+25, 0, 128'h208);
    add_lit(t+6, 3, 128'd0); add_lit(t+14, 3, 128'd1); add_lit(t+28, 3, 128'd2);
    add_lit(t+30, 2, '0);
    t = te; gap(t, 2);

    // Address wrap at the top of memory
    plan_batch(t, 16'hFFFE, 1, 2, 0, 0, 0, -1, 1'b0, te);
    add_lit(t+1, 0, 128'hFFFE); add_lit(t+2, 0, 128'hFFFF); add_lit(t+3, 0, 128'h0000);
    t = te; gap(t, 2);

    // Empty batch
    plan_batch(t, 16'h1234, 0, 0, 0, 0, 0, -1, 1'b0, te);
    add_lit(t+1, 2, '0);
    t = te; gap(t, 3);

    // Reset while waiting for vertex 1 of 4, then a fresh single vertex
    plan_batch(t, 16'h0300, 4, 1, 2, 0, 0, 1, 1'b1, te);
    t = te; gap(t, 4);
    plan_batch(t, 16'h0100, 1, 0, 0, 0, 0, -1, 1'b0, te);
    add_lit(t+1, 0, 128'h100); add_lit(t+2, 0, 128'h101); add_lit(t+3, 0, 128'h102);
    add_lit(t+6, 1, {32'h3F80_0000, 32'h3E23_F10F, 32'h3E20_F10C, 32'h3E21_F10D});
    t = te; gap(t, 2);

    // Randomized batches
    for (int b = 0; b < 25 && t < MAXC - 200; b++) begin
      n = $urandom_range(0, 4);
      plan_batch(t, 16'($urandom), n, $urandom_range(0, 6), $urandom_range(0, 6),
                 $urandom_range(0, 6), $urandom_range(0, 6), -1,
                 $urandom_range(0, 1) == 1, te);
      t = te;
      gap(t, $urandom_range(0, 3));
    end
    endc = t + 12;

    // The address output holds its last read address; reset zeroes it.
    cur = '0;
    for (int k = 0; k < endc; k++) begin
      if (exp_rst[k]) cur = '0;
      else if (exp_rd[k]) cur = exp_ra[k];
      exp_addr[k] = cur;
    end

    for (int k = 0; k < endc; k++) begin
      @(posedge clk_in);
      #1;
      apply_stimulus(k);
      cur_k   = k;
      running = 1'b1;
    end
    @(posedge clk_in);
    #1;
    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
